// File: rtl/video_pkg.sv
// video_pkg: shared video widths, status bit positions and line-delay defaults
package video_pkg;
   localparam int DATA_W       = 24;
   localparam int STAT_W       = 3;
   localparam int HS           = 0;
   localparam int VS           = 1;
   localparam int DE           = 2;
   localparam int LINE_LEN_DEF = 1650;
   localparam int FILL_MAX     = 4;
   typedef struct packed {
      logic [STAT_W-1:0] stat;
      logic [DATA_W-1:0] data;
   } pix_t;
endpackage

// File: rtl/bram_delay_if.sv
// bram_delay_if: pixel/status stream in, five-tap column and aligned status out
interface bram_delay_if;
   import video_pkg::*;
   logic [DATA_W-1:0] data_in, pa, pb, pc, pd, pe;
   logic [STAT_W-1:0] stat_in, stat_o;
   modport master (output data_in, stat_in, input pa, pb, pc, pd, pe, stat_o);
   modport slave (input data_in, stat_in, output pa, pb, pc, pd, pe, stat_o);
endinterface

// File: rtl/line_delay.sv
// line_delay: one line of block RAM, written at wr_addr and read one clock ahead at rd_addr
module line_delay #(
   parameter int W = 8,
   parameter int LINE_LEN = 2,
   localparam int ADDR_W = $clog2(LINE_LEN)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [W-1:0]      wr_data,
   output logic [W-1:0]      rd_data
);
   logic [W-1:0] mem [LINE_LEN];
   logic [W-1:0] rd_data_q;
   // rd_addr is the next write address, so rd_data holds that word's old value when it is overwritten
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      rd_data_q <= mem[rd_addr];
   end
   assign rd_data = rd_data_q;
endmodule

// File: rtl/bram_delay.sv
// bram_delay: four chained line buffers giving a five-line pixel column plus centre-aligned status
module bram_delay import video_pkg::*; #(
   parameter int LINE_LEN = LINE_LEN_DEF
) (
   input logic         clk,
   input logic         rst,
   bram_delay_if.slave bus
);
   localparam int ADDR_W = $clog2(LINE_LEN);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_LEN - 1);
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [2:0] fill_q, fill_d;
   logic [DATA_W-1:0] pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d, pe_q, pe_d;
   logic [STAT_W-1:0] stat_q, stat_d;
   pix_t l1_rd, l2_rd;
   logic [DATA_W-1:0] l3_rd, l4_rd;
   logic wrap;
   // next pointer/fill count; taps are masked by the fill count seen before this edge
   always_comb begin
      wrap   = ptr_q == LAST;
      ptr_d  = wrap ? '0 : ptr_q + ADDR_W'(1);
      fill_d = (wrap && fill_q != 3'(FILL_MAX)) ? fill_q + 3'd1 : fill_q;
      pe_d   = bus.data_in;
      pd_d   = fill_q >= 3'd1 ? l1_rd.data : '0;
      pc_d   = fill_q >= 3'd2 ? l2_rd.data : '0;
      pb_d   = fill_q >= 3'd3 ? l3_rd : '0;
      pa_d   = fill_q >= 3'd4 ? l4_rd : '0;
      stat_d = fill_q >= 3'd2 ? l2_rd.stat : '0;
   end
   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q  <= '0;
         fill_q <= '0;
         pa_q   <= '0;
         pb_q   <= '0;
         pc_q   <= '0;
         pd_q   <= '0;
         pe_q   <= '0;
         stat_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         fill_q <= fill_d;
         pa_q   <= pa_d;
         pb_q   <= pb_d;
         pc_q   <= pc_d;
         pd_q   <= pd_d;
         pe_q   <= pe_d;
         stat_q <= stat_d;
      end
   end
   line_delay #(.W($bits(pix_t)), .LINE_LEN(LINE_LEN)) u_l1 (
      .clk(clk), .we(rst), .wr_addr(ptr_q), .rd_addr(ptr_d),
      .wr_data({bus.stat_in, bus.data_in}), .rd_data(l1_rd)
   );
   line_delay #(.W($bits(pix_t)), .LINE_LEN(LINE_LEN)) u_l2 (
      .clk(clk), .we(rst), .wr_addr(ptr_q), .rd_addr(ptr_d),
      .wr_data(l1_rd), .rd_data(l2_rd)
   );
   line_delay #(.W(DATA_W), .LINE_LEN(LINE_LEN)) u_l3 (
      .clk(clk), .we(rst), .wr_addr(ptr_q), .rd_addr(ptr_d),
      .wr_data(l2_rd.data), .rd_data(l3_rd)
   );
   line_delay #(.W(DATA_W), .LINE_LEN(LINE_LEN)) u_l4 (
      .clk(clk), .we(rst), .wr_addr(ptr_q), .rd_addr(ptr_d),
      .wr_data(l3_rd), .rd_data(l4_rd)
   );
   assign bus.pa     = pa_q;
   assign bus.pb     = pb_q;
   assign bus.pc     = pc_q;
   assign bus.pd     = pd_q;
   assign bus.pe     = pe_q;
   assign bus.stat_o = stat_q;
endmodule

// File: tb/tb_bram_delay.sv
// tb_bram_delay: history-queue reference model plus fill/status tables for bram_delay
module tb_bram_delay;
   import video_pkg::*;
   logic clk = 1'b0;
   logic rst8 = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;
   bram_delay_if b8 ();
   bram_delay_if bb ();
   bram_delay #(.LINE_LEN(8)) dut8 (.clk(clk), .rst(rst8), .bus(b8));
   bram_delay dutb (.clk(clk), .rst(rstb), .bus(bb));
   int errors = 0;
   int checks = 0;
   logic [DATA_W-1:0] xq[$];
   logic [STAT_W-1:0] sq[$];
   logic [DATA_W-1:0] o[5];
   logic [STAT_W-1:0] o_s;
   typedef struct {
      int k;
      logic [DATA_W-1:0] pe, pd, pc, pb, pa;
   } vec_t;
   vec_t tbl[8];
   int hi[3];
   task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got=%0h want=%0h", name, k, act, exp);
      end
   endtask
   function automatic int cur_k();
      return xq.size() - 1;
   endfunction
   function automatic logic [DATA_W-1:0] tap(input int n, input int l);
      int k = cur_k();
      return (k >= n * l) ? xq[k - n * l] : '0;
   endfunction
   function automatic logic [STAT_W-1:0] stap(input int l);
      int k = cur_k();
      return (k >= 2 * l) ? sq[k - 2 * l] : '0;
   endfunction
   function automatic logic [STAT_W-1:0] spat(input int k);
      logic [STAT_W-1:0] s;
      s[0] = (k == 5) || (k == 20) || (k == 21);
      s[1] = (k >= 22) && (k <= 25);
      s[2] = ((k >= 10) && (k <= 13)) || ((k >= 24) && (k <= 29));
      return s;
   endfunction
   task automatic step(input bit big, input logic [DATA_W-1:0] d, input logic [STAT_W-1:0] s, input logic r);
      if (big) begin
         bb.data_in = d;
         bb.stat_in = s;
         rstb = r;
      end else begin
         b8.data_in = d;
         b8.stat_in = s;
         rst8 = r;
      end
      @(posedge clk);
      #1;
      if (!r) begin
         xq.delete();
         sq.delete();
      end else begin
         xq.push_back(d);
         sq.push_back(s);
      end
      o[0] = big ? bb.pe : b8.pe;
      o[1] = big ? bb.pd : b8.pd;
      o[2] = big ? bb.pc : b8.pc;
      o[3] = big ? bb.pb : b8.pb;
      o[4] = big ? bb.pa : b8.pa;
      o_s  = big ? bb.stat_o : b8.stat_o;
   endtask
   task automatic check_model(input int l);
      for (int n = 0; n < 5; n++) cmp($sformatf("tap%0d", n), cur_k(), 32'(o[n]), 32'(tap(n, l)));
      cmp("stat_o", cur_k(), 32'(o_s), 32'(stap(l)));
   endtask
   task automatic check_table();
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].k == cur_k()) begin
            cmp("tbl_pe", cur_k(), 32'(o[0]), 32'(tbl[i].pe));
            cmp("tbl_pd", cur_k(), 32'(o[1]), 32'(tbl[i].pd));
            cmp("tbl_pc", cur_k(), 32'(o[2]), 32'(tbl[i].pc));
            cmp("tbl_pb", cur_k(), 32'(o[3]), 32'(tbl[i].pb));
            cmp("tbl_pa", cur_k(), 32'(o[4]), 32'(tbl[i].pa));
         end
      end
   endtask
   initial begin
      tbl[0] = '{7, 7, 0, 0, 0, 0};
      tbl[1] = '{8, 8, 0, 0, 0, 0};
      tbl[2] = '{9, 9, 1, 0, 0, 0};
      tbl[3] = '{16, 16, 8, 0, 0, 0};
      tbl[4] = '{17, 17, 9, 1, 0, 0};
      tbl[5] = '{32, 32, 24, 16, 8, 0};
      tbl[6] = '{33, 33, 25, 17, 9, 1};
      tbl[7] = '{40, 40, 32, 24, 16, 8};
      bb.data_in = '0;
      bb.stat_in = '0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, DATA_W'($urandom), STAT_W'($urandom), 1'b0);
         check_model(8);
      end
      hi = '{0, 0, 0};
      for (int k = 0; k < 50; k++) begin
         step(1'b0, DATA_W'(k), spat(k), 1'b1);
         check_model(8);
         check_table();
         for (int b = 0; b < 3; b++) hi[b] += int'(o_s[b]);
         if (k == 20 || k == 22 || k == 30) cmp("stat_quiet", k, 32'(o_s), 0);
         if (k == 21) cmp("stat_hs_pulse", k, 32'(o_s), 1);
         if (k == 26 || k == 29) cmp("stat_de_pulse", k, 32'(o_s), 4);
      end
      cmp("width_b0", 49, hi[0], 3);
      cmp("width_b1", 49, hi[1], 4);
      cmp("width_b2", 49, hi[2], 10);
      step(1'b0, 24'hABCDEF, 3'b111, 1'b0);
      for (int n = 0; n < 5; n++) cmp($sformatf("midrst_tap%0d", n), 50, 32'(o[n]), 0);
      cmp("midrst_stat", 50, 32'(o_s), 0);
      for (int k = 0; k < 800; k++) begin
         step(1'b0, DATA_W'(k), STAT_W'($urandom), 1'b1);
         check_model(8);
         check_table();
         if (k >= 32) begin
            cmp("pd_minus8", k, 32'(o[1]), 32'(k - 8));
            cmp("pa_minus32", k, 32'(o[4]), 32'(k - 32));
         end
      end
      step(1'b1, '0, '0, 1'b0);
      step(1'b1, '0, '0, 1'b0);
      check_model(1650);
      for (int k = 0; k < 4 * 1650 + 300; k++) begin
         step(1'b1, DATA_W'($urandom), STAT_W'($urandom), 1'b1);
         check_model(1650);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
